// File: rtl/sd_pkg.sv
// sd_pkg: SD controller state/command codes and error codes.
package sd_pkg;
    // State code equals the SD command index issued in that state
    typedef enum logic [5:0] {
        IDLE   = 6'd0,
        CMD2   = 6'd2,
        CMD3   = 6'd3,
        ACMD6  = 6'd6,
        CMD7   = 6'd7,
        CMD15  = 6'd15,
        CMD17  = 6'd17,
        READ   = 6'd19,
        WRITE  = 6'd20,
        CMD24  = 6'd24,
        ACMD41 = 6'd41,
        CMD55  = 6'd55
    } sd_state_e;
    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_CMD55  = 3'd1;
    localparam logic [2:0] ERR_ACMD41 = 3'd2;
    localparam logic [2:0] ERR_ACMD6  = 3'd3;
    localparam logic [2:0] ERR_RETRY  = 3'd4;
endpackage

// File: rtl/sd_retry_cnt.sv
// sd_retry_cnt: saturating event counter; ohit means the next event reaches LIMIT.
module sd_retry_cnt #(
    parameter int LIMIT = 3
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic iclr,
    input  logic iinc,
    output logic ohit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign ohit = 32'(cnt) + 1 >= LIMIT;
    always_ff @(posedge iclk or negedge irst_n)
        if (!irst_n)
            cnt <= '0;
        else if (iclr)
            cnt <= '0;
        else if (iinc && !ohit)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/sd_ctrl_fsm.sv
// sd_ctrl_fsm: SD card init and read-modify-write block loop controller.
module sd_ctrl_fsm
    import sd_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int NUM_BLOCKS   = 0,
    parameter int MAX_RETRY    = 3,
    parameter int INIT_TIMEOUT = 1000,
    parameter int WIDE_BUS     = 1
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              istart,
    input  logic              icmd_done,
    input  logic [31:0]       iresp,
    input  logic              idata_crc_fail,
    input  logic              idata_done,
    input  logic              iotp_ready,
    output logic              osel_clk,
    output logic              ogen_otp,
    output logic              onew_otp,
    output logic              ostart_cmd,
    output logic [5:0]        oindex,
    output logic [31:0]       oarg,
    output logic              ostart_d,
    output logic              obusy,
    output logic              osuccess,
    output logic              ofail,
    output logic [2:0]        oerr,
    output logic [ADDR_W-1:0] oblk_cnt
);
    sd_state_e   state;
    logic        start_q, done_seen, acc, read_ok, crc_hit, busy_hit, last_blk;
    logic [15:0] rca;
    logic        unused_resp;
    assign acc       = state == IDLE && istart && !start_q;
    assign read_ok   = state == READ && !idata_crc_fail && (done_seen || idata_done) && iotp_ready;
    assign last_blk  = NUM_BLOCKS != 0 && 32'(oblk_cnt) + 1 == NUM_BLOCKS;
    assign obusy     = state != IDLE;
    assign onew_otp  = state == IDLE;
    assign oindex    = state;
    assign unused_resp = ^{iresp[15:13], iresp[8:6], iresp[4:0]};
    // The block counter doubles as the card block address
    assign oarg = (state == CMD55 && !osel_clk) ? 32'h0000_FFFF :
                  (state inside {CMD55, CMD7, CMD15}) ? {rca, 16'hFFFF} :
                  state == ACMD41 ? 32'h8030_0000 :
                  state == ACMD6 ? 32'hFFFF_FFFE :
                  (state inside {CMD17, CMD24}) ? 32'(oblk_cnt) << 9 : '1;
    sd_retry_cnt #(.LIMIT(MAX_RETRY)) u_crc (
        .iclk, .irst_n, .iclr(acc || read_ok),
        .iinc(state == READ && idata_crc_fail), .ohit(crc_hit)
    );
    sd_retry_cnt #(.LIMIT(INIT_TIMEOUT + 1)) u_busy (
        .iclk, .irst_n, .iclr(acc),
        .iinc(state == ACMD41 && icmd_done && iresp[21:20] != 2'b00 && !iresp[31]), .ohit(busy_hit)
    );
    always_ff @(posedge iclk or negedge irst_n)
        if (!irst_n) begin
            state <= IDLE; start_q <= 1'b0; done_seen <= 1'b0; rca <= '0; oblk_cnt <= '0;
            ostart_cmd <= 1'b0; ostart_d <= 1'b0; ogen_otp <= 1'b0; osel_clk <= 1'b0;
            osuccess <= 1'b0; ofail <= 1'b0; oerr <= ERR_NONE;
        end else begin
            start_q <= istart;
            ostart_cmd <= 1'b0;
            ostart_d <= 1'b0;
            ogen_otp <= 1'b0;
            done_seen <= state == READ && !idata_crc_fail && !read_ok && (done_seen || idata_done);
            case (state)
                IDLE: if (acc) begin
                    state <= CMD55; ostart_cmd <= 1'b1; osuccess <= 1'b0; ofail <= 1'b0;
                    oerr <= ERR_NONE; oblk_cnt <= '0;
                end
                CMD55: if (icmd_done) begin
                    if (!iresp[5]) begin
                        state <= IDLE; ofail <= 1'b1; oerr <= ERR_CMD55; osel_clk <= 1'b0;
                    end else begin
                        state <= osel_clk ? ACMD6 : ACMD41; ostart_cmd <= 1'b1;
                    end
                end
                ACMD41: if (icmd_done) begin
                    if (iresp[21:20] == 2'b00 || (!iresp[31] && busy_hit)) begin
                        state <= IDLE; ofail <= 1'b1; oerr <= ERR_ACMD41; osel_clk <= 1'b0;
                    end else begin
                        state <= iresp[31] ? CMD2 : CMD55; ostart_cmd <= 1'b1;
                    end
                end
                CMD2: if (icmd_done) begin
                    state <= CMD3; ostart_cmd <= 1'b1;
                end
                CMD3: if (icmd_done) begin
                    state <= CMD7; ostart_cmd <= 1'b1; rca <= iresp[31:16]; osel_clk <= 1'b1;
                end
                CMD7: if (icmd_done) begin
                    state <= (WIDE_BUS != 0) ? CMD55 : CMD17; ostart_cmd <= 1'b1; ostart_d <= WIDE_BUS == 0;
                end
                ACMD6: if (icmd_done) begin
                    if (iresp[12:9] != 4'd4) begin
                        state <= IDLE; ofail <= 1'b1; oerr <= ERR_ACMD6; osel_clk <= 1'b0;
                    end else begin
                        state <= CMD17; ostart_cmd <= 1'b1; ostart_d <= 1'b1;
                    end
                end
                CMD17: if (icmd_done) begin
                    state <= iresp[31] ? CMD15 : READ; ostart_cmd <= iresp[31]; ogen_otp <= !iresp[31];
                end
                READ: if (idata_crc_fail) begin
                    if (crc_hit) begin
                        state <= IDLE; ofail <= 1'b1; oerr <= ERR_RETRY; osel_clk <= 1'b0;
                    end else begin
                        state <= CMD17; ostart_cmd <= 1'b1; ostart_d <= 1'b1;
                    end
                end else if (read_ok) begin
                    state <= CMD24; ostart_cmd <= 1'b1;
                end
                CMD24: if (icmd_done) begin
                    state <= WRITE; ostart_d <= 1'b1;
                end
                WRITE: if (idata_done) begin
                    oblk_cnt <= oblk_cnt + 1'b1; state <= last_blk ? CMD15 : CMD17;
                    ostart_cmd <= 1'b1; ostart_d <= !last_blk;
                end
                CMD15: if (icmd_done) begin
                    state <= IDLE; osuccess <= 1'b1; osel_clk <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_sd_ctrl_fsm.sv
// tb_sd_ctrl_fsm: randomized card responder checked against expected command traces.
module tb_sd_ctrl_fsm;
    logic iclk = 1'b0, irst_n = 1'b0;
    logic istart_a = 1'b0, istart_b = 1'b0, icmd_done = 1'b0;
    logic idata_crc_fail = 1'b0, idata_done = 1'b0, iotp_ready = 1'b0;
    logic [31:0] iresp = '0;
    always #5 iclk = ~iclk;

    logic a_sel, a_gen, a_new, a_cmd, a_d, a_busy, a_succ, a_fail;
    logic [5:0] a_idx;
    logic [31:0] a_arg;
    logic [2:0] a_err;
    logic [22:0] a_blk;
    logic b_sel, b_gen, b_new, b_cmd, b_d, b_busy, b_succ, b_fail;
    logic [5:0] b_idx;
    logic [31:0] b_arg;
    logic [2:0] b_err;
    logic [1:0] b_blk;

    sd_ctrl_fsm #(.ADDR_W(23), .NUM_BLOCKS(2), .MAX_RETRY(3), .INIT_TIMEOUT(4), .WIDE_BUS(1)) u_a (
        .iclk(iclk), .irst_n(irst_n), .istart(istart_a), .icmd_done(icmd_done), .iresp(iresp),
        .idata_crc_fail(idata_crc_fail), .idata_done(idata_done), .iotp_ready(iotp_ready),
        .osel_clk(a_sel), .ogen_otp(a_gen), .onew_otp(a_new), .ostart_cmd(a_cmd), .oindex(a_idx),
        .oarg(a_arg), .ostart_d(a_d), .obusy(a_busy), .osuccess(a_succ), .ofail(a_fail),
        .oerr(a_err), .oblk_cnt(a_blk));
    sd_ctrl_fsm #(.ADDR_W(2), .NUM_BLOCKS(0), .MAX_RETRY(3), .INIT_TIMEOUT(4), .WIDE_BUS(0)) u_b (
        .iclk(iclk), .irst_n(irst_n), .istart(istart_b), .icmd_done(icmd_done), .iresp(iresp),
        .idata_crc_fail(idata_crc_fail), .idata_done(idata_done), .iotp_ready(iotp_ready),
        .osel_clk(b_sel), .ogen_otp(b_gen), .onew_otp(b_new), .ostart_cmd(b_cmd), .oindex(b_idx),
        .oarg(b_arg), .ostart_d(b_d), .obusy(b_busy), .osuccess(b_succ), .ofail(b_fail),
        .oerr(b_err), .oblk_cnt(b_blk));

    bit sel = 1'b0;
    logic m_cmd, m_gen, m_d, m_busy, m_succ, m_fail, m_sel;
    logic [5:0] m_idx;
    logic [31:0] m_arg, m_blk;
    logic [2:0] m_err;
    assign m_cmd  = sel ? b_cmd : a_cmd;
    assign m_gen  = sel ? b_gen : a_gen;
    assign m_d    = sel ? b_d : a_d;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_succ = sel ? b_succ : a_succ;
    assign m_fail = sel ? b_fail : a_fail;
    assign m_sel  = sel ? b_sel : a_sel;
    assign m_idx  = sel ? b_idx : a_idx;
    assign m_arg  = sel ? b_arg : a_arg;
    assign m_err  = sel ? b_err : a_err;
    assign m_blk  = sel ? 32'(b_blk) : 32'(a_blk);

    int n_d = 0, n_otp = 0;
    logic [5:0] obs_idx[$];
    logic [31:0] obs_arg[$];
    always @(negedge iclk) begin
        if (m_gen) n_otp++;
        if (m_d) n_d++;
        if (m_cmd) begin
            obs_idx.push_back(m_idx);
            obs_arg.push_back(m_arg);
        end
    end

    int checks = 0, failures = 0;
    int busy_n, oor_at, stop_wr_blk, sz0, d0, o0;
    bit bad55, vrej, bad6;
    logic [15:0] rca16;
    int crc[8];
    logic [5:0] exp_idx[$];
    logic [31:0] exp_arg[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scen(input int bn, input bit b55, input bit vr, input bit b6, input int oor, input int stw);
        busy_n = bn; bad55 = b55; vrej = vr; bad6 = b6; oor_at = oor; stop_wr_blk = stw;
        rca16 = 16'($urandom);
        foreach (crc[i]) crc[i] = 0;
        exp_idx.delete();
        exp_arg.delete();
    endtask

    task automatic add(input int idx, input logic [31:0] arg);
        exp_idx.push_back(6'(idx));
        exp_arg.push_back(arg);
    endtask

    task automatic add_init(input int k, input bit wide);
        for (int j = 0; j <= k; j++) begin
            add(55, 32'h0000_FFFF);
            add(41, 32'h8030_0000);
        end
        add(2, '1);
        add(3, '1);
        add(7, {rca16, 16'hFFFF});
        if (wide) begin
            add(55, {rca16, 16'hFFFF});
            add(6, 32'hFFFF_FFFE);
        end
    endtask

    task automatic add_block(input int b, input int c, input int aw);
        logic [31:0] a;
        a = 32'((b % (1 << aw)) * 512);
        for (int j = 0; j <= c; j++) add(17, a);
        add(24, a);
    endtask

    task automatic check_trace();
        int n;
        n = obs_idx.size() - sz0;
        chk("trace_len", n, exp_idx.size());
        for (int i = 0; i < n && i < exp_idx.size(); i++) begin
            chk($sformatf("cmd%0d_idx", i), obs_idx[sz0 + i], exp_idx[i]);
            chk($sformatf("cmd%0d_arg", i), obs_arg[sz0 + i], exp_arg[i]);
        end
    endtask

    task automatic chk_end(input bit s, input bit f, input int e, input int blk);
        chk("osuccess", m_succ, s);
        chk("ofail", m_fail, f);
        chk("oerr", m_err, e);
        chk("oblk_cnt", m_blk, blk);
        chk("osel_clk_end", m_sel, 0);
    endtask

    task automatic set_start(input logic v);
        if (sel) istart_b = v;
        else istart_a = v;
    endtask

    task automatic wait_rand();
        repeat ($urandom_range(0, 2)) @(negedge iclk);
    endtask

    // Plays the card: answers each command and drives the data phases
    task automatic run(input bit s);
        int blk, busy, g;
        logic [5:0] idx;
        logic [31:0] r;
        bit oor;
        sel = s; sz0 = obs_idx.size(); d0 = n_d; o0 = n_otp; blk = 0; busy = 0; oor = 1'b0;
        @(negedge iclk);
        set_start(1'b1);
        @(negedge iclk);
        for (int step = 0; step < 400; step++) begin
            for (g = 0; g < 60 && !m_cmd && m_busy; g++) @(negedge iclk);
            if (!m_busy) break;
            if (!m_cmd) begin
                chk("cmd_wait", m_cmd, 1);
                break;
            end
            idx = m_idx;
            wait_rand();
            r = $urandom;
            case (idx)
                55: r[5] = !bad55;
                41: begin
                    r[21:20] = vrej ? 2'b00 : 2'($urandom_range(1, 3));
                    r[31] = busy >= busy_n;
                    if (!r[31]) busy++;
                end
                3: r[31:16] = rca16;
                6: r[12:9] = bad6 ? 4'($urandom_range(0, 3)) : 4'd4;
                17: begin
                    oor = blk == oor_at;
                    r[31] = oor;
                end
                default: ;
            endcase
            icmd_done = 1'b1; iresp = r;
            @(negedge iclk);
            icmd_done = 1'b0; iresp = $urandom;
            if (idx == 24 && blk == stop_wr_blk) return;
            if (idx == 17 && !oor) begin
                if (crc[blk] > 0) begin
                    wait_rand();
                    idata_crc_fail = 1'b1;
                    @(negedge iclk);
                    idata_crc_fail = 1'b0;
                    crc[blk]--;
                end else if ($urandom_range(0, 1) == 1) begin
                    iotp_ready = 1'b1;
                    wait_rand();
                    idata_done = 1'b1;
                    @(negedge iclk);
                    idata_done = 1'b0; iotp_ready = 1'b0;
                end else begin
                    wait_rand();
                    idata_done = 1'b1;
                    @(negedge iclk);
                    idata_done = 1'b0;
                    wait_rand();
                    iotp_ready = 1'b1;
                    @(negedge iclk);
                    iotp_ready = 1'b0;
                end
            end
            if (idx == 24) begin
                set_start(1'b0);
                @(negedge iclk);
                set_start(1'b1);
                wait_rand();
                idata_done = 1'b1;
                @(negedge iclk);
                idata_done = 1'b0;
                blk++;
            end
        end
        repeat (3) @(negedge iclk);
        chk("idle_hold", m_busy, 0);
        set_start(1'b0);
    endtask

    task automatic full_a();
        int bn, c0, c1;
        bn = $urandom_range(0, 3); c0 = $urandom_range(0, 2); c1 = $urandom_range(0, 2);
        scen(bn, 0, 0, 0, -1, -1);
        crc[0] = c0; crc[1] = c1;
        add_init(bn, 1);
        add_block(0, c0, 23);
        add_block(1, c1, 23);
        add(15, {rca16, 16'hFFFF});
        run(0);
        check_trace();
        chk_end(1, 0, 0, 2);
        chk("ogen_otp_cnt", n_otp - o0, c0 + c1 + 2);
        chk("ostart_d_cnt", n_d - d0, c0 + c1 + 4);
    endtask

    initial begin
        #1;
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_new", a_new, 1);
        chk("rst_a_arg", a_arg, 32'hFFFF_FFFF);
        chk("rst_a_flags", {a_succ, a_fail, a_sel, a_cmd, a_d, a_gen}, 0);
        chk("rst_a_err_blk", {a_err, a_blk}, 0);
        chk("rst_b_idx", b_idx, 0);
        chk("rst_b_arg", b_arg, 32'hFFFF_FFFF);
        @(negedge iclk);
        irst_n = 1'b1;
        repeat (2) full_a();
        scen(0, 0, 0, 0, -1, -1);
        crc[0] = 3;
        add_init(0, 1);
        add(17, 0); add(17, 0); add(17, 0);
        run(0);
        check_trace();
        chk_end(0, 1, 4, 0);
        scen(1000, 0, 0, 0, -1, -1);
        for (int j = 0; j < 5; j++) begin
            add(55, 32'h0000_FFFF);
            add(41, 32'h8030_0000);
        end
        run(0);
        check_trace();
        chk_end(0, 1, 2, 0);
        scen(0, 1, 0, 0, -1, -1);
        add(55, 32'h0000_FFFF);
        run(0);
        check_trace();
        chk_end(0, 1, 1, 0);
        scen(0, 0, 1, 0, -1, -1);
        add(55, 32'h0000_FFFF);
        add(41, 32'h8030_0000);
        run(0);
        check_trace();
        chk_end(0, 1, 2, 0);
        scen(1, 0, 0, 1, -1, -1);
        add_init(1, 1);
        run(0);
        check_trace();
        chk_end(0, 1, 3, 0);
        scen(0, 0, 0, 0, -1, 1);
        run(0);
        chk("wr_busy", a_busy, 1);
        chk("wr_idx", a_idx, 20);
        chk("wr_blk", a_blk, 1);
        chk("wr_sel", a_sel, 1);
        #2 irst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_idx", a_idx, 0);
        chk("arst_new", a_new, 1);
        chk("arst_arg", a_arg, 32'hFFFF_FFFF);
        chk("arst_flags", {a_succ, a_fail, a_sel}, 0);
        chk("arst_err_blk", {a_err, a_blk}, 0);
        istart_a = 1'b0;
        @(negedge iclk);
        irst_n = 1'b1;
        full_a();
        begin
            int bn, m;
            int cs[8];
            bn = $urandom_range(0, 2); m = $urandom_range(4, 6);
            scen(bn, 0, 0, 0, m, -1);
            add_init(bn, 0);
            for (int b = 0; b < m; b++) begin
                cs[b] = $urandom_range(0, 1);
                crc[b] = cs[b];
                add_block(b, cs[b], 2);
            end
            add(17, 32'((m % 4) * 512));
            add(15, {rca16, 16'hFFFF});
            run(1);
            check_trace();
            chk_end(1, 0, 0, m % 4);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/sd_ctrl_fsm.md
SD_CTRL_FSM -- requirements
Module: sd_ctrl_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, meaning width of block address (arg bits [ADDR_W+8:9]); legal range 1..23.
REQ-002 SHALL have parameter NUM_BLOCKS, default 0, meaning blocks processed per run; 0 = run until card reports out-of-range.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning CRC-failed read attempts allowed per block before abort.
REQ-004 SHALL have parameter INIT_TIMEOUT, default 1000, meaning maximum ACMD41 busy responses before abort.
REQ-005 SHALL have parameter WIDE_BUS, default 1, meaning 1 = switch card to 4-bit via ACMD6, 0 = stay 1-bit and skip ACMD6.
REQ-006 SHALL have ports, one clock and asynchronous active-low reset: iclk in 1 clock; irst_n in 1 async active-low reset.
REQ-007 SHALL have inputs: istart 1 level start request; icmd_done 1 command/response complete; iresp 32 card response; idata_crc_fail 1 read CRC error pulse; idata_done 1 data phase done pulse; iotp_ready 1 pad generated.
REQ-008 SHALL have outputs: osel_clk 1 fast clock select; ogen_otp 1 pad generate pulse; onew_otp 1 new pad request; ostart_cmd 1 command launch pulse; oindex 6 command index; oarg 32 command argument; ostart_d 1 data launch pulse; obusy 1 run active; osuccess 1; ofail 1; oerr 3 error code; oblk_cnt ADDR_W blocks completed.

Function
REQ-009 SHALL accept a start only on the rising edge of istart (registered edge detect) while in IDLE; edges elsewhere ignored.
REQ-010 SHALL implement states IDLE, CMD55, ACMD41, CMD2, CMD3, CMD7, ACMD6, CMD17, READ(19), CMD24, WRITE(20), CMD15; state code equals command index; oindex = state code.
REQ-011 SHALL transition on icmd_done: CMD55 -> iresp[5] ? (osel_clk ? ACMD6 : ACMD41) : IDLE; ACMD41 -> no iresp[21:20] bit ? IDLE : iresp[31] ? CMD2 : CMD55; CMD2->CMD3; CMD3->CMD7; CMD7 -> WIDE_BUS ? CMD55 : CMD17; ACMD6 -> iresp[12:9]==4 ? CMD17 : IDLE; CMD17 -> iresp[31] ? CMD15 : READ; CMD24->WRITE; CMD15->IDLE.
REQ-012 SHALL in READ: idata_crc_fail has priority -> CMD17 (retry, same address); else sticky data_done and iotp_ready -> CMD24; data_done sticky clears on any state change.
REQ-013 SHALL count CRC failures per block; the MAX_RETRY-th failure -> IDLE, ofail, oerr=4; counter clears on READ->CMD24.
REQ-014 SHALL in WRITE on data_done: increment block address and oblk_cnt; if NUM_BLOCKS!=0 and new oblk_cnt==NUM_BLOCKS -> CMD15, else -> CMD17.
REQ-015 SHALL count ACMD41 busy responses (iresp[31]=0); exceeding INIT_TIMEOUT -> IDLE, ofail, oerr=2.
REQ-016 SHALL set oerr: 0 none, 1 CMD55 bad response, 2 ACMD41 voltage reject or timeout, 3 ACMD6 bad bus width, 4 retry exhausted.
REQ-017 SHALL capture RCA from iresp[31:16] on the transition into CMD7.
REQ-018 SHALL drive oarg combinationally: default all ones; CMD55 pre-select [31:16]=0; ACMD41 = 0x8030_0000; CMD7, CMD55 post-select, CMD15 [31:16]=RCA; ACMD6 bit0=0; CMD17/CMD24 [8:0]=0, [ADDR_W+8:9]=address, upper bits 0.
REQ-019 SHALL set osel_clk on entry to CMD7, clear on entry to IDLE.
REQ-020 SHALL pulse ostart_cmd one cycle, first cycle of every command state; ostart_d on entry to CMD17 and WRITE; ogen_otp on entry to READ.
REQ-021 SHALL assert osuccess on CMD15->IDLE; ofail on any other non-IDLE->IDLE; both hold until next accepted start, which clears them, oerr, oblk_cnt, address and counters.
REQ-022 SHALL drive obusy = state!=IDLE, onew_otp = state==IDLE.
REQ-023 SHALL wrap address modulo 2^ADDR_W without error when NUM_BLOCKS=0.

Reset
REQ-024 SHALL on irst_n low asynchronously force IDLE and all registered outputs, counters, RCA, address to 0; oarg then reads all ones, onew_otp 1.
REQ-025 SHALL abort any run mid-operation on reset without asserting ofail or osuccess.

Structure
REQ-026 SHALL place state/command codes and oerr codes in shared package sd_pkg.
REQ-027 SHALL use one sub-module sd_retry_cnt (saturating counter, clear/inc/limit-hit) for CRC retry and ACMD41 timeout.

Verification
REQ-028 Full run, NUM_BLOCKS=2, good responses -> two CMD17/CMD24 pairs, addresses 0 then 512, CMD15, osuccess=1, oblk_cnt=2.
REQ-029 Three idata_crc_fail in READ, MAX_RETRY=3 -> CMD17 reissued twice, then IDLE, ofail=1, oerr=4.
REQ-030 ACMD41 busy forever, INIT_TIMEOUT=4 -> abort after 5th busy response, oerr=2.
REQ-031 WIDE_BUS=0 -> CMD7 followed directly by CMD17, no ACMD6 issued.
REQ-032 irst_n low during WRITE -> immediate IDLE, all outputs 0, no ofail; next istart edge runs normally.
